// File: rtl/pc_branch_unit.sv
// PC sequencer for the jump/branch decoder: resolves branches, registers the next PC,
// drives the link strobe, latches halt and keeps saturating CCMB statistics counters.
module pc_branch_unit #(
  parameter int                  PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int                  CNT_WIDTH = 16
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_enable,
  input  logic                 in_halt,
  input  logic                 in_J,
  input  logic                 in_JW,
  input  logic                 in_JR,
  input  logic                 in_BEQ,
  input  logic                 in_BNE,
  input  logic                 in_BGEZ,
  input  logic                 in_equal,
  input  logic [PC_WIDTH-1:0]  in_rs_value,
  input  logic [15:0]          in_imm16,
  input  logic [25:0]          in_target26,
  output logic [PC_WIDTH-1:0]  out_pc,
  output logic [PC_WIDTH-1:0]  out_pc_plus4,
  output logic                 out_link_we,
  output logic                 out_redirect,
  output logic                 out_halted,
  output logic [CNT_WIDTH-1:0] out_total_cycles,
  output logic [CNT_WIDTH-1:0] out_uncond_cnt,
  output logic [CNT_WIDTH-1:0] out_cond_taken_cnt
);

  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic                 halted_q, halted_d;
  logic [CNT_WIDTH-1:0] total_q, total_d;
  logic [CNT_WIDTH-1:0] uncond_q, uncond_d;
  logic [CNT_WIDTH-1:0] cond_q, cond_d;

  logic                 act;
  logic                 advance;
  logic                 taken;
  logic                 is_jump;
  logic [PC_WIDTH-1:0]  pc_plus4;
  logic [PC_WIDTH-1:0]  branch_off;
  logic [PC_WIDTH-1:0]  branch_target;
  logic [PC_WIDTH-1:0]  jump_target;
  logic [PC_WIDTH-1:0]  jr_target;
  logic [PC_WIDTH-1:0]  next_pc;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                   input logic                 en);
    sat_inc = (en && (cnt != '1)) ? cnt + CNT_WIDTH'(1) : cnt;
  endfunction

  always_comb begin
    act           = in_enable & ~halted_q;
    advance       = act & ~in_halt;
    is_jump       = in_J | in_JR;
    taken         = in_BEQ  ? in_equal :
                    in_BNE  ? ~in_equal :
                    in_BGEZ ? ~in_rs_value[PC_WIDTH-1] : 1'b0;
    pc_plus4      = pc_q + PC_WIDTH'(4);
    branch_off    = {{(PC_WIDTH-18){in_imm16[15]}}, in_imm16, 2'b00};
    branch_target = pc_plus4 + branch_off;
    jump_target   = {pc_plus4[PC_WIDTH-1:28], in_target26, 2'b00};
    // Clearing the low bits by mask keeps the JR target word aligned.
    jr_target     = in_rs_value & ~PC_WIDTH'(3);

    next_pc = pc_plus4;
    if (in_JR)      next_pc = jr_target;
    else if (in_J)  next_pc = jump_target;
    else if (taken) next_pc = branch_target;
  end

  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_q;
    if (advance) pc_d = next_pc;
    if (act && in_halt) halted_d = 1'b1;
    total_d  = sat_inc(total_q, act);
    uncond_d = sat_inc(uncond_q, advance & is_jump);
    cond_d   = sat_inc(cond_q, advance & ~is_jump & taken);
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
      total_q  <= '0;
      uncond_q <= '0;
      cond_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
      total_q  <= total_d;
      uncond_q <= uncond_d;
      cond_q   <= cond_d;
    end
  end

  assign out_pc             = pc_q;
  assign out_pc_plus4       = pc_plus4;
  assign out_link_we        = advance & in_JW;
  assign out_redirect       = advance & (is_jump | taken) & (next_pc != pc_plus4);
  assign out_halted         = halted_q;
  assign out_total_cycles   = total_q;
  assign out_uncond_cnt     = uncond_q;
  assign out_cond_taken_cnt = cond_q;

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Downstream consumer of the jump/branch control decoder's J, JW, JR, BEQ, BNE and BGEZ flags.
- Resolves branch conditions, selects and registers the next PC, and drives the link-write strobe for jump-and-link.
- Implements the sticky halt latch.
- Holds the CCMB statistics counters: total cycles, unconditional jumps and taken conditional branches, which feed the display logic.

Parameters:
- PC_WIDTH, 32, width of PC and all address datapaths (must be ≥ 28 + 2 for J target concatenation)
- RESET_PC, 0, PC value loaded on reset
- CNT_WIDTH, 16, width of each statistics counter

Ports:
- in_clk  input  1  system clock, all state updates on rising edge
- in_rst  input  1  synchronous, active-high reset
- in_enable  input  1  1 = advance this cycle; 0 = stall (all state held)
- in_halt  input  1  current instruction is a halt
- in_J  input  1  unconditional jump (also asserted with JR)
- in_JW  input  1  jump-and-link, write return address
- in_JR  input  1  jump to register
- in_BEQ  input  1  branch if equal
- in_BNE  input  1  branch if not equal
- in_BGEZ  input  1  branch if rs ≥ 0
- in_equal  input  1  rs == rt, from ALU comparator
- in_rs_value  input  PC_WIDTH  register rs contents
- in_imm16  input  16  instruction immediate field
- in_target26  input  26  instruction jump target field
- out_pc  output  PC_WIDTH  current PC, registered
- out_pc_plus4  output  PC_WIDTH  out_pc + 4, combinational; also the link value
- out_link_we  output  1  register-file write strobe for the link value
- out_redirect  output  1  next PC ≠ out_pc_plus4 this cycle
- out_halted  output  1  sticky halt flag, registered
- out_total_cycles  output  CNT_WIDTH  executed-cycle counter
- out_uncond_cnt  output  CNT_WIDTH  unconditional jump counter
- out_cond_taken_cnt  output  CNT_WIDTH  taken conditional branch counter

Behaviour:
- Reset:
  - Synchronous reset has priority over every other input.
  - Reset values: out_pc = RESET_PC, out_halted = 0, all counters = 0.
  - Reset asserted mid-stall or while halted clears everything on the next edge.
- Active cycle: act = in_enable & ~out_halted.
- Branch condition:
  - taken = BEQ ? in_equal : BNE ? ~in_equal : BGEZ ? ~in_rs_value[PC_WIDTH-1] : 0.
  - Priority is BEQ > BNE > BGEZ if the decoder asserts more than one.
- Next-PC priority:
  1. in_JR: {in_rs_value[PC_WIDTH-1:2], 2'b00}
  2. in_J: {out_pc_plus4[PC_WIDTH-1:28], in_target26, 2'b00}
  3. taken: out_pc_plus4 + (sign-extended in_imm16 << 2), modulo 2^PC_WIDTH (wrap, no trap)
  4. otherwise: out_pc_plus4, which wraps from all-ones-minus-3 to 0
- Halt:
  - If act & in_halt, out_halted is set on the edge and out_pc does NOT update; it stays at the halt instruction.
  - Jump/branch flags in the halt cycle are ignored.
  - out_halted clears only on reset.
- PC update: out_pc <= next PC only when act & ~in_halt. Otherwise out_pc holds.
- out_redirect:
  - Combinational.
  - Equals act & ~in_halt & (in_JR | in_J | taken) & (next PC ≠ out_pc_plus4).
  - A branch whose target equals pc+4 does not redirect.
- out_link_we:
  - Combinational, = act & ~in_halt & in_JW.
  - Written value is out_pc_plus4.
- Counters:
  - All counters saturate at all-ones and never wrap.
  - out_total_cycles: +1 on every act cycle, including the halt cycle.
  - out_uncond_cnt: +1 when act & ~in_halt & (in_J | in_JR); a single JR counts once.
  - out_cond_taken_cnt: +1 when act & ~in_halt & ~(in_J | in_JR) & taken.
- Stall (in_enable = 0): no register changes; out_link_we = 0, out_redirect = 0.
- Latency:
  - Next PC is visible on out_pc one cycle after the decision.
  - Strobes are same-cycle combinational.

Test Plan:
- Sequential fetch: reset, RESET_PC = 0, no flags, in_enable = 1 for 4 cycles → out_pc 0, 4, 8, 12, then 16; out_total_cycles = 4; other counters 0; out_redirect = 0 throughout.
- Branches:
  - out_pc = 0x100, in_BEQ = 1, in_equal = 1, in_imm16 = 0xFFFF → next out_pc = 0x100, out_redirect = 1, out_cond_taken_cnt +1.
  - Repeat with in_equal = 0 → out_pc = 0x104, counter unchanged.
  - in_BGEZ with in_rs_value = 0x80000000 → not taken.
- Jumps:
  - out_pc = 0x30000010, in_J = 1, in_JW = 1, in_target26 = 0x0000040 → out_link_we = 1, link value 0x30000014; next out_pc = 0x30000100; out_uncond_cnt = 1.
  - in_J = in_JR = 1, in_rs_value = 0x00000407 → out_pc = 0x00000404; out_uncond_cnt increments by exactly 1.
- Halt and stall:
  - in_enable = 0 for 3 cycles → all outputs held, strobes 0.
  - Then in_halt = 1 at out_pc = 0x20 → out_halted = 1, out_pc stays 0x20, total increments once, then frozen despite in_enable = 1 and further flags.
  - Assert in_rst → out_pc = RESET_PC, out_halted = 0, counters 0.
- Saturation: CNT_WIDTH = 4, run 20 active cycles with in_BNE = 1, in_equal = 0, in_imm16 = 0 → out_total_cycles and out_cond_taken_cnt stick at 0xF; out_redirect = 0 because the target equals pc+4.
